serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only when busy=0.
REQ-005 SHALL have port: op_sub  input  1  0 = a+b+cin, 1 = a-b (computed as a + ~b + 1); sampled with start.
REQ-006 SHALL have ports: a, b  input  WIDTH  operands; sampled with start.
REQ-007 SHALL have port: cin  input  1  carry-in for add; ignored when op_sub=1.
REQ-008 SHALL have ports: fa_a, fa_b, fa_cin  output  1 each  drive the external one-bit full-adder cell.
REQ-009 SHALL have ports: fa_sum, fa_cout  input  1 each  combinational results from that cell.
REQ-010 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports: sum  output  WIDTH, cout  output  1  registered result; cout is the no-borrow flag when op_sub=1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after WIDTH bit cycles, DONE->IDLE unconditionally unless a new start is accepted.
REQ-014 SHALL, on the accepting edge E0, load a into a shift register, b (inverted if op_sub) into b shift register, carry <= (op_sub ? 1 : cin), bit counter <= 0.
REQ-015 SHALL, in RUN, drive fa_a = a_sh[0], fa_b = b_sh[0], fa_cin = carry combinationally from registers.
REQ-016 SHALL, on each RUN edge, shift a_sh/b_sh right by one, shift fa_sum into the MSB of a partial-sum register, carry <= fa_cout, counter +1.
REQ-017 SHALL leave RUN on the edge where counter = WIDTH-1 (edge E_WIDTH), copying the completed partial sum to sum and fa_cout to cout on that same edge.
REQ-018 SHALL assert busy from after E0 until E_WIDTH (exactly WIDTH cycles) and assert done for exactly the one cycle after E_WIDTH.
REQ-019 SHALL hold sum/cout stable between completions; intermediate shifting SHALL NOT be visible on sum.
REQ-020 SHALL ignore start while busy=1 (no reload, no restart, no state change).
REQ-021 SHALL accept start during the DONE cycle (busy=0), entering RUN directly; done still pulses for that cycle.
REQ-022 SHALL drive fa_a, fa_b, fa_cin to 0 in IDLE and DONE.
REQ-023 SHALL treat all arithmetic modulo 2^WIDTH; the carry out of the MSB goes only to cout.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously force state=IDLE, busy=0, done=0, sum=0, cout=0, fa_* = 0, counter/carry/shift registers = 0.
REQ-025 SHALL abandon any in-progress operation on reset without producing done; sum/cout read 0 afterward.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-027 SHALL pass: WIDTH=8, a=0xFF, b=0x01, cin=0, op_sub=0, start at E0 -> busy for 8 cycles, done at cycle 9, sum=0x00, cout=1.
REQ-028 SHALL pass: a=0x05, b=0x07, op_sub=1 -> sum=0xFE, cout=0; then a=0x07, b=0x05, op_sub=1 -> sum=0x02, cout=1.
REQ-029 SHALL pass: a=0x3C, b=0x0F, cin=1, start re-pulsed with a=0xFF mid-RUN -> second start ignored, sum=0x4C, cout=0.
REQ-030 SHALL pass: start asserted in DONE cycle with a=0x10, b=0x20 -> busy reasserts next cycle, next done gives sum=0x30 with no idle cycle between.
REQ-031 SHALL pass: rst_n pulsed low at bit 4 of a running operation -> busy, done, sum, cout go 0 immediately; no done pulse follows.
REQ-032 SHALL pass: bench models the full-adder cell behaviourally and checks fa_a/fa_b/fa_cin against the expected bit each RUN cycle, and fa_* = 0 in IDLE.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial add/subtract controller. Streams two operands LSB
//            first through an external one-bit full-adder cell, collects the
//            sum bits and presents a registered WIDTH-bit result plus carry.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bit counter only has to reach WIDTH-1; keep it at least one bit wide.
    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_psum;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [c_CW-1:0]  r_cnt;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus status and full-adder drive outputs.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_cin   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                fa_a   = r_a_sh[0];
                fa_b   = r_b_sh[0];
                fa_cin = r_carry;
                if (r_cnt == c_LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                // busy is low here, so a new request chains straight into RUN.
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand shifters, running carry, partial sum and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            r_a_sh  <= a;
            r_b_sh  <= op_sub ? ~b : b;
            r_psum  <= '0;
            r_carry <= op_sub | cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_psum  <= {fa_sum, r_psum[WIDTH-1:1]};
            r_carry <= fa_cout;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Result register updates only on the final bit so shifting never shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= {fa_sum, r_psum[WIDTH-1:1]};
            r_cout <= fa_cout;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl with a behavioural
//            full-adder cell and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int              c_W    = 8;
    localparam longint unsigned c_MASK = (64'd1 << c_W) - 64'd1;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b1;
    logic           start  = 1'b0;
    logic           op_sub = 1'b0;
    logic           cin    = 1'b0;
    logic [c_W-1:0] a      = '0;
    logic [c_W-1:0] b      = '0;
    logic           fa_a, fa_b, fa_cin;
    logic           fa_sum, fa_cout;
    logic           busy, done, cout;
    logic [c_W-1:0] sum;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: operands as streamed and the last result.
    longint unsigned m_a, m_b, m_c0;
    longint unsigned exp_sum  = 0;
    longint unsigned exp_cout = 0;

    serial_add_ctrl #(.WIDTH(c_W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_sub  (op_sub),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    // Behavioural one-bit full adder.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input longint unsigned obs,
                             input longint unsigned exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_fa_a"}, fa_a, 0);
        check_val({tag, "_fa_b"}, fa_b, 0);
        check_val({tag, "_fa_cin"}, fa_cin, 0);
    endtask

    // Present a request for one edge, then scramble the operand inputs.
    task automatic start_op(input logic [c_W-1:0] ia, input logic [c_W-1:0] ib,
                            input logic iop, input logic ic);
        a = ia; b = ib; op_sub = iop; cin = ic; start = 1'b1;
        m_a  = ia;
        m_b  = iop ? (~longint'(ib) & c_MASK) : longint'(ib);
        m_c0 = iop ? 1 : longint'(ic);
        @(posedge clk); #1;
        start = 1'b0;
        a = c_W'($urandom); b = c_W'($urandom);
        op_sub = 1'($urandom); cin = 1'($urandom);
    endtask

    // Walk the WIDTH run cycles, optionally re-pulsing start mid-run.
    task automatic run_body(input int restart_at);
        longint unsigned lo, t, p_sum, p_cout;
        p_sum  = exp_sum;
        p_cout = exp_cout;
        for (int k = 0; k < c_W; k++) begin
            lo = (64'd1 << k) - 64'd1;
            t  = (m_a & lo) + (m_b & lo) + m_c0;
            check_val("run_busy", busy, 1);
            check_val("run_done", done, 0);
            check_val("run_sum_hold", sum, p_sum);
            check_val("run_cout_hold", cout, p_cout);
            check_val("run_fa_a", fa_a, (m_a >> k) & 1);
            check_val("run_fa_b", fa_b, (m_b >> k) & 1);
            check_val("run_fa_cin", fa_cin, (t >> k) & 1);
            if (k == restart_at) begin
                start = 1'b1; a = '1; b = c_W'($urandom); op_sub = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        t        = m_a + m_b + m_c0;
        exp_sum  = t & c_MASK;
        exp_cout = (t >> c_W) & 1;
        check_val("done_pulse", done, 1);
        check_quiet("done");
        check_val("done_sum", sum, exp_sum);
        check_val("done_cout", cout, exp_cout);
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
        check_val("idle_done", done, 0);
        check_quiet("idle");
        check_val("idle_sum", sum, exp_sum);
        check_val("idle_cout", cout, exp_cout);
    endtask

    initial begin
        // Asynchronous reset: outputs must clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_async_busy", busy, 0);
        check_val("rst_async_done", done, 0);
        check_val("rst_async_sum", sum, 0);
        check_val("rst_async_cout", cout, 0);
        check_quiet("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle_cycle();

        // 0xFF + 0x01: wraps to 0 with carry out.
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_body(-1);
        check_val("wrap_sum", sum, 8'h00);
        check_val("wrap_cout", cout, 1);
        idle_cycle();

        // Subtraction both ways; cout is the no-borrow flag.
        start_op(8'h05, 8'h07, 1'b1, 1'b1);
        run_body(-1);
        check_val("sub_neg_sum", sum, 8'hFE);
        check_val("sub_neg_cout", cout, 0);
        idle_cycle();
        start_op(8'h07, 8'h05, 1'b1, 1'b0);
        run_body(-1);
        check_val("sub_pos_sum", sum, 8'h02);
        check_val("sub_pos_cout", cout, 1);
        idle_cycle();

        // Start re-pulsed mid-run must be ignored.
        start_op(8'h3C, 8'h0F, 1'b0, 1'b1);
        run_body(3);
        check_val("restart_sum", sum, 8'h4C);
        check_val("restart_cout", cout, 0);

        // Back-to-back: new request accepted in the DONE cycle.
        start_op(8'h10, 8'h20, 1'b0, 1'b0);
        run_body(-1);
        check_val("b2b_sum", sum, 8'h30);
        idle_cycle();

        // Reset during bit 4 of a running operation.
        start_op(8'hA5, 8'h5A, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_sum", sum, 0);
        check_val("midrst_cout", cout, 0);
        check_quiet("midrst");
        exp_sum  = 0;
        exp_cout = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check_val("midrst_no_done", done, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        idle_cycle();
        idle_cycle();

        // Randomized traffic with chained requests and stray starts.
        for (int i = 0; i < 60; i++) begin
            int ra;
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c_W - 2)) : -1;
            start_op(c_W'($urandom), c_W'($urandom), 1'($urandom), 1'($urandom));
            run_body(ra);
            if ($urandom_range(0, 2) != 0) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
